// File: rtl/fpu_normalizer.sv
// Normalise/round/pack stage behind the fpu add/sub datapath; one left shift per cycle, subnormals flush to zero.
// Optional round-to-nearest-even is enabled by defining FPU_NORM_ROUND_EN (default build truncates).
module fpu_normalizer #(
    parameter int bitness = 32,
    localparam int EW   = (bitness == 16) ? 5 : 8,
    localparam int MW   = (bitness == 16) ? 10 : 23,
    localparam int BIAS = (bitness == 16) ? 15 : 127
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_rdy,
    output logic                in_ack,
    input  logic                in_sign,
    input  logic [EW+1:0]       in_exp,
    input  logic [MW+4:0]       in_mant,
    output logic                out_rdy,
    input  logic                out_ack,
    output logic [bitness-1:0]  result,
    output logic                flag_zero,
    output logic                flag_ovf,
    output logic                flag_unf,
    output logic [2:0]          dbg_state_o
);

    // Handshakes: in_ack is a one-cycle pulse registered on the edge that captures in_*;
    // out_rdy stays high with result/flags frozen until out_ack is sampled high alongside it.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_SHIFT_L = 3'd2,
        S_ROUND   = 3'd3,
        S_PACK    = 3'd4,
        S_OUTPUT  = 3'd5
    } state_t;

    localparam logic signed [EW+1:0] EXP_ONE  = (EW+2)'(1);
    localparam logic signed [EW+1:0] EXP_MAX  = (EW+2)'(BIAS);
    localparam logic signed [EW+1:0] EXP_MIN  = (EW+2)'(1 - BIAS);
    localparam logic signed [EW+1:0] EXP_BIAS = (EW+2)'(BIAS);

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic signed [EW+1:0]   exp_q, exp_d;
    logic [MW+4:0]          mant_q, mant_d;
    logic                   zero_q, zero_d;
    logic                   in_ack_q, in_ack_d;
    logic                   out_rdy_q, out_rdy_d;
    logic [bitness-1:0]     result_q, result_d;
    logic                   flag_zero_q, flag_zero_d;
    logic                   flag_ovf_q, flag_ovf_d;
    logic                   flag_unf_q, flag_unf_d;

    logic [EW-1:0]          exp_field;
`ifdef FPU_NORM_ROUND_EN
    logic                   round_inc;
    logic [MW+4:0]          mant_round;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            zero_q      <= 1'b0;
            in_ack_q    <= 1'b0;
            out_rdy_q   <= 1'b0;
            result_q    <= '0;
            flag_zero_q <= 1'b0;
            flag_ovf_q  <= 1'b0;
            flag_unf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            zero_q      <= zero_d;
            in_ack_q    <= in_ack_d;
            out_rdy_q   <= out_rdy_d;
            result_q    <= result_d;
            flag_zero_q <= flag_zero_d;
            flag_ovf_q  <= flag_ovf_d;
            flag_unf_q  <= flag_unf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        zero_d      = zero_q;
        in_ack_d    = 1'b0;
        out_rdy_d   = out_rdy_q;
        result_d    = result_q;
        flag_zero_d = flag_zero_q;
        flag_ovf_d  = flag_ovf_q;
        flag_unf_d  = flag_unf_q;
        exp_field   = EW'(exp_q + EXP_BIAS);
`ifdef FPU_NORM_ROUND_EN
        round_inc   = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        mant_round  = mant_q + {{(MW+1){1'b0}}, round_inc, 3'b000};
`endif

        case (state_q)
            S_IDLE: begin
                if (in_rdy) begin
                    sign_d      = in_sign;
                    exp_d       = in_exp;
                    mant_d      = in_mant;
                    zero_d      = 1'b0;
                    flag_zero_d = 1'b0;
                    flag_ovf_d  = 1'b0;
                    flag_unf_d  = 1'b0;
                    in_ack_d    = 1'b1;
                    state_d     = S_CHECK;
                end
            end

            S_CHECK: begin
                if (mant_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = S_PACK;
                end else if (mant_q[MW+4]) begin
                    // Carry out of the adder: fold the dropped bit into sticky.
                    mant_d  = {1'b0, mant_q[MW+4:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = S_ROUND;
                end else if (!mant_q[MW+3]) begin
                    state_d = S_SHIFT_L;
                end else begin
                    state_d = S_ROUND;
                end
            end

            S_SHIFT_L: begin
                // Nonzero mantissa with no carry guarantees termination within MW+3 shifts.
                mant_d = {mant_q[MW+3:0], 1'b0};
                exp_d  = exp_q - EXP_ONE;
                if (mant_q[MW+2]) begin
                    state_d = S_ROUND;
                end
            end

            S_ROUND: begin
`ifdef FPU_NORM_ROUND_EN
                if (mant_round[MW+4]) begin
                    mant_d = {1'b0, mant_round[MW+4:1]};
                    exp_d  = exp_q + EXP_ONE;
                end else begin
                    mant_d = mant_round;
                end
`endif
                state_d = S_PACK;
            end

            S_PACK: begin
                if (zero_q) begin
                    result_d    = {sign_q, {(bitness-1){1'b0}}};
                    flag_zero_d = 1'b1;
                end else if (exp_q > EXP_MAX) begin
                    result_d   = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
                    flag_ovf_d = 1'b1;
                end else if (exp_q < EXP_MIN) begin
                    result_d    = {sign_q, {(bitness-1){1'b0}}};
                    flag_unf_d  = 1'b1;
                    flag_zero_d = 1'b1;
                end else begin
                    result_d = {sign_q, exp_field, mant_q[MW+2:3]};
                end
                state_d = S_OUTPUT;
            end

            S_OUTPUT: begin
                // First OUTPUT cycle raises out_rdy; the ack is only honoured once it is visible.
                if (!out_rdy_q) begin
                    out_rdy_d = 1'b1;
                end else if (out_ack) begin
                    out_rdy_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ack      = in_ack_q;
    assign out_rdy     = out_rdy_q;
    assign result      = result_q;
    assign flag_zero   = flag_zero_q;
    assign flag_ovf    = flag_ovf_q;
    assign flag_unf    = flag_unf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fpu_normalizer.sv
// Directed bench for fpu_normalizer at bitness=32; expected words are hand-computed IEEE-754 values.
module tb_fpu_normalizer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_rdy;
    logic        in_ack;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_rdy;
    logic        out_ack;
    logic [31:0] result;
    logic        flag_zero;
    logic        flag_ovf;
    logic        flag_unf;
    logic [2:0]  dbg_state_o;

    int n_vec = 0;
    int n_bad = 0;

    fpu_normalizer #(.bitness(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_rdy      (in_rdy),
        .in_ack      (in_ack),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_mant     (in_mant),
        .out_rdy     (out_rdy),
        .out_ack     (out_ack),
        .result      (result),
        .flag_zero   (flag_zero),
        .flag_ovf    (flag_ovf),
        .flag_unf    (flag_unf),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a triple, wait for in_ack, then count edges until out_rdy.
    task automatic apply(input logic s, input logic [9:0] e, input logic [27:0] m,
                         output int lat, output int ack_extra);
        int cyc;
        in_sign = s;
        in_exp  = e;
        in_mant = m;
        in_rdy  = 1'b1;
        cyc = 0;
        while (in_ack !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("ack_seen", {31'd0, in_ack}, 32'd1);
        in_rdy = 1'b0;
        lat = 0;
        ack_extra = 0;
        while (out_rdy !== 1'b1 && lat < 100) begin
            step();
            lat++;
            if (in_ack === 1'b1) ack_extra++;
        end
    endtask

    task automatic release_result(input string tag);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk(tag, {31'd0, out_rdy}, 32'd0);
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, flag_zero, flag_ovf, flag_unf}, {29'd0, exp});
    endtask

    initial begin
        int lat;
        int ack_extra;
        logic [31:0] held;

        reset   = 1'b1;
        in_rdy  = 1'b0;
        in_sign = 1'b0;
        in_exp  = '0;
        in_mant = '0;
        out_ack = 1'b0;
        repeat (3) step();
        chk("rst_out_rdy", {31'd0, out_rdy}, 32'd0);
        chk("rst_in_ack", {31'd0, in_ack}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk_flags("rst_flags", 3'b000);
        reset = 1'b0;
        step();

        // 1.0
        apply(1'b0, 10'd0, 28'h400_0000, lat, ack_extra);
        chk("one_result", result, 32'h3F80_0000);
        chk("one_latency", lat, 32'd4);
        chk("one_ack_pulse", ack_extra, 32'd0);
        chk_flags("one_flags", 3'b000);
        release_result("one_release");

        // Carry in: 2.0
        apply(1'b0, 10'd0, 28'h800_0000, lat, ack_extra);
        chk("carry_result", result, 32'h4000_0000);
        chk("carry_latency", lat, 32'd4);
        release_result("carry_release");

        // Six left shifts: 2^-6
        apply(1'b0, 10'd0, 28'h010_0000, lat, ack_extra);
        chk("shl_result", result, 32'h3C80_0000);
        chk("shl_latency", lat, 32'd10);
        release_result("shl_release");

        // Negative zero
        apply(1'b1, 10'd0, 28'h000_0000, lat, ack_extra);
        chk("zero_result", result, 32'h8000_0000);
        chk_flags("zero_flags", 3'b100);
        release_result("zero_release");

        // Overflow to +inf
        apply(1'b0, 10'd128, 28'h400_0000, lat, ack_extra);
        chk("ovf_result", result, 32'h7F80_0000);
        chk_flags("ovf_flags", 3'b010);
        release_result("ovf_release");

        // Largest normal exponent, flags cleared from the previous op
        apply(1'b0, 10'd127, 28'h400_0000, lat, ack_extra);
        chk("emax_result", result, 32'h7F00_0000);
        chk_flags("emax_flags", 3'b000);
        release_result("emax_release");

        // Underflow flush
        apply(1'b0, 10'h381, 28'h400_0000, lat, ack_extra);
        chk("unf_result", result, 32'h0000_0000);
        chk_flags("unf_flags", 3'b101);
        release_result("unf_release");

        // Smallest normal exponent (-126)
        apply(1'b0, 10'h382, 28'h400_0000, lat, ack_extra);
        chk("emin_result", result, 32'h0080_0000);
        chk_flags("emin_flags", 3'b000);
        release_result("emin_release");

        // -3.0 (exp 1, mantissa 1.5)
        apply(1'b1, 10'd1, 28'h600_0000, lat, ack_extra);
        chk("neg_result", result, 32'hC040_0000);
        release_result("neg_release");

        // Rounding cases
        apply(1'b0, 10'd0, 28'h400_0007, lat, ack_extra);
`ifdef FPU_NORM_ROUND_EN
        chk("rnd_up_result", result, 32'h3F80_0001);
`else
        chk("rnd_up_result", result, 32'h3F80_0000);
`endif
        chk("rnd_up_latency", lat, 32'd4);
        release_result("rnd_up_release");

        apply(1'b0, 10'd0, 28'h7FF_FFFC, lat, ack_extra);
`ifdef FPU_NORM_ROUND_EN
        chk("rnd_carry_result", result, 32'h4000_0000);
`else
        chk("rnd_carry_result", result, 32'h3FFF_FFFF);
`endif
        release_result("rnd_carry_release");

        // Tie with even LSB stays put when rounding; truncation gives the same word
        apply(1'b0, 10'd0, 28'h400_0004, lat, ack_extra);
        chk("rnd_tie_result", result, 32'h3F80_0000);
        release_result("rnd_tie_release");

        // Back-pressure: hold out_ack low, poke in_rdy
        apply(1'b0, 10'd1, 28'h400_0000, lat, ack_extra);
        held = result;
        chk("hold_first", held, 32'h4000_0000);
        for (int i = 0; i < 10; i++) begin
            in_rdy  = i[0];
            in_sign = 1'b1;
            in_mant = 28'h0;
            step();
            chk("hold_out_rdy", {31'd0, out_rdy}, 32'd1);
            chk("hold_result", result, 32'h4000_0000);
            chk("hold_no_ack", {31'd0, in_ack}, 32'd0);
        end
        in_rdy = 1'b0;
        release_result("hold_release");

        // Reset while shifting (bit 4 needs 22 shifts)
        in_sign = 1'b0;
        in_exp  = 10'd0;
        in_mant = 28'h000_0010;
        in_rdy  = 1'b1;
        lat = 0;
        while (in_ack !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("mid_ack_seen", {31'd0, in_ack}, 32'd1);
        in_rdy = 1'b0;
        repeat (3) step();
        chk("mid_in_shift", {29'd0, dbg_state_o}, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_state", {29'd0, dbg_state_o}, 32'd0);
        chk("mid_rst_out_rdy", {31'd0, out_rdy}, 32'd0);
        chk("mid_rst_result", result, 32'h0);
        repeat (30) step();
        chk("mid_abandoned", {31'd0, out_rdy}, 32'd0);

        // Recovery after reset
        apply(1'b0, 10'd0, 28'h400_0000, lat, ack_extra);
        chk("recover_result", result, 32'h3F80_0000);
        chk("recover_latency", lat, 32'd4);
        release_result("recover_release");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
